ppu_fetch_gen: RTL and testbench

- Bus-master model of the NES PPU memory fetch sequence. It is the transmitter end of the PPU bus that mapper logic snoops.
- It drives ppu_addr and ppu_oe with exact per-dot timing: nametable, attribute and pattern fetches; sprite fetches; and the dummy nametable reads that mappers use for scanline and in-frame detection.
- Uses: stimulus source for mapper scanline/IRQ verification, and the PPU-side engine for the standalone PPU-bus test harness.

---
 rtl/ppu_fetch_gen_pkg.sv | 29 ++
 rtl/ppu_fetch_gen_dot_ctr.sv | 88 ++++++++
 rtl/ppu_fetch_gen.sv | 167 ++++++++++++++++
 tb/tb_ppu_fetch_gen.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_fetch_gen_pkg.sv
// Shared fetch-kind encoding, dot-window boundaries and PPU bus address constants
// for the PPU fetch generator.
package ppu_fetch_gen_pkg;

    typedef enum logic [2:0] {
        FkIdle,
        FkNt,
        FkAt,
        FkPtLo,
        FkPtHi
    } fetch_kind_e;

    localparam logic [8:0] DotBgFirst  = 9'd1;
    localparam logic [8:0] DotBgLast   = 9'd256;
    localparam logic [8:0] DotSprFirst = 9'd257;
    localparam logic [8:0] DotSprLast  = 9'd320;
    localparam logic [8:0] DotPreFirst = 9'd321;
    localparam logic [8:0] DotPreLast  = 9'd336;
    localparam logic [8:0] DotDumFirst = 9'd337;
    localparam logic [8:0] DotDumLast  = 9'd340;

    localparam logic [13:0] NtAddrBase = 14'h2000;
    localparam logic [9:0]  AtOffset   = 10'h3C0;

    function automatic logic in_range(logic [8:0] d, logic [8:0] lo, logic [8:0] hi);
        return (d >= lo) && (d <= hi);
    endfunction

endpackage

// File: rtl/ppu_fetch_gen_dot_ctr.sv
// Dot/line/frame counters for the PPU fetch generator, with the odd-frame dot skip
// and vblank/NMI generation. Also exposes the next position for registered decode.
module ppu_dot_ctr #(
    parameter int unsigned DOTS     = 341,
    parameter int unsigned LINES    = 262,
    parameter int unsigned VBL_LINE = 241
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       dot_ce_i,
    input  logic       rend_on_i,
    output logic [8:0] dot_o,
    output logic [8:0] line_o,
    output logic [8:0] dot_nxt_o,
    output logic [8:0] line_nxt_o,
    output logic       frame_odd_o,
    output logic       vblank_o,
    output logic       nmi_pulse_o
);

    localparam logic [8:0] DotLast  = 9'(DOTS - 1);
    localparam logic [8:0] DotSkip  = 9'(DOTS - 2);
    localparam logic [8:0] LineLast = 9'(LINES - 1);
    localparam logic [8:0] VblLine  = 9'(VBL_LINE);

    logic [8:0] dot_q, dot_d;
    logic [8:0] line_q, line_d;
    logic       odd_q, odd_d;
    logic       vbl_q, vbl_d;
    logic       nmi_q, nmi_d;
    logic       skip;

    // Odd rendered frames drop the last dot of the pre-render line.
    assign skip = rend_on_i && odd_q && (line_q == LineLast) && (dot_q == DotSkip);

    always_comb begin
        dot_d  = dot_q;
        line_d = line_q;
        odd_d  = odd_q;
        vbl_d  = vbl_q;
        nmi_d  = 1'b0;
        if (dot_ce_i) begin
            if ((dot_q == DotLast) || skip) begin
                dot_d = 9'd0;
                if (line_q == LineLast) begin
                    line_d = 9'd0;
                    odd_d  = ~odd_q;
                end else begin
                    line_d = line_q + 9'd1;
                end
            end else begin
                dot_d = dot_q + 9'd1;
            end
            if ((line_d == VblLine) && (dot_d == 9'd1)) begin
                vbl_d = 1'b1;
                nmi_d = 1'b1;
            end
            if ((line_d == LineLast) && (dot_d == 9'd1)) begin
                vbl_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dot_q  <= 9'd0;
            line_q <= 9'd0;
            odd_q  <= 1'b0;
            vbl_q  <= 1'b0;
            nmi_q  <= 1'b0;
        end else begin
            dot_q  <= dot_d;
            line_q <= line_d;
            odd_q  <= odd_d;
            vbl_q  <= vbl_d;
            nmi_q  <= nmi_d;
        end
    end

    assign dot_o       = dot_q;
    assign line_o      = line_q;
    assign dot_nxt_o   = dot_d;
    assign line_nxt_o  = line_d;
    assign frame_odd_o = odd_q;
    assign vblank_o    = vbl_q;
    assign nmi_pulse_o = nmi_q;

endmodule

// File: rtl/ppu_fetch_gen.sv
// NES PPU bus master: drives the per-dot nametable/attribute/pattern fetch sequence,
// sprite fetches and dummy NT reads that mappers snoop for scanline detection.
module ppu_fetch_gen
    import ppu_fetch_gen_pkg::*;
#(
    parameter int unsigned DOTS      = 341,
    parameter int unsigned LINES     = 262,
    parameter int unsigned VBL_LINE  = 241,
    parameter int unsigned VIS_LINES = 240
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        dot_ce_i,
    input  logic        rend_on_i,
    input  logic [1:0]  nt_base_i,
    input  logic        bg_tbl_i,
    input  logic        spr_tbl_i,
    input  logic [7:0]  ppu_dat_i,
    output logic [13:0] ppu_addr_o,
    output logic        ppu_oe_o,
    output logic [8:0]  dot_o,
    output logic [8:0]  line_o,
    output logic        frame_odd_o,
    output logic        vblank_o,
    output logic        nmi_pulse_o
);

    localparam logic [8:0] LineLast = 9'(LINES - 1);
    localparam logic [8:0] VisLines = 9'(VIS_LINES);

    logic [8:0]  dot_cur, dot_nxt, line_nxt;
    logic [2:0]  ph_cur, ph_nxt;
    logic        bg_cur, bg_nxt, spr_nxt, dum_nxt;
    logic        pre_nxt, fetch_en;
    logic [7:0]  row;
    logic [4:0]  cy, cx_f, cy_f;
    logic        pt_tbl;
    logic [7:0]  pt_tile;
    logic [2:0]  pt_fy;
    logic [13:0] nt_sel;
    fetch_kind_e kind;

    logic [13:0] addr_q, addr_d;
    logic        oe_q, oe_d;
    logic [7:0]  tile_q, tile_d;
    logic [4:0]  coarse_x_q, coarse_x_d;

    ppu_dot_ctr #(
        .DOTS     (DOTS),
        .LINES    (LINES),
        .VBL_LINE (VBL_LINE)
    ) u_dot_ctr (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .dot_ce_i    (dot_ce_i),
        .rend_on_i   (rend_on_i),
        .dot_o       (dot_cur),
        .line_o      (line_o),
        .dot_nxt_o   (dot_nxt),
        .line_nxt_o  (line_nxt),
        .frame_odd_o (frame_odd_o),
        .vblank_o    (vblank_o),
        .nmi_pulse_o (nmi_pulse_o)
    );

    // Outputs are registered, so everything is decoded from the dot being entered.
    assign ph_nxt   = 3'(dot_nxt - 9'd1);
    assign ph_cur   = 3'(dot_cur - 9'd1);
    assign bg_nxt   = in_range(dot_nxt, DotBgFirst, DotBgLast)
                   || in_range(dot_nxt, DotPreFirst, DotPreLast);
    assign bg_cur   = in_range(dot_cur, DotBgFirst, DotBgLast)
                   || in_range(dot_cur, DotPreFirst, DotPreLast);
    assign spr_nxt  = in_range(dot_nxt, DotSprFirst, DotSprLast);
    assign dum_nxt  = in_range(dot_nxt, DotDumFirst, DotDumLast);
    assign pre_nxt  = (line_nxt == LineLast);
    assign fetch_en = rend_on_i && ((line_nxt < VisLines) || pre_nxt);

    // Pre-render fetches as line 0; tail-of-line fetches prefetch the next row.
    always_comb begin
        row = 8'd0;
        if (!pre_nxt) begin
            row = (dot_nxt <= DotBgLast) ? line_nxt[7:0] : line_nxt[7:0] + 8'd1;
        end
    end
    assign cy = row[7:3];

    always_comb begin
        coarse_x_d = coarse_x_q;
        if (dot_ce_i) begin
            if (in_range(dot_nxt, DotBgFirst, DotBgLast)) begin
                coarse_x_d = 5'((dot_nxt - DotBgFirst) >> 3);
            end else if (in_range(dot_nxt, DotPreFirst, DotPreLast)) begin
                coarse_x_d = 5'((dot_nxt - DotPreFirst) >> 3);
            end else if (dot_nxt == DotSprFirst) begin
                coarse_x_d = 5'd0;
            end
        end
    end

    always_comb begin
        kind = FkIdle;
        if (bg_nxt) begin
            case (ph_nxt[2:1])
                2'd0:    kind = FkNt;
                2'd1:    kind = FkAt;
                2'd2:    kind = FkPtLo;
                default: kind = FkPtHi;
            endcase
        end else if (spr_nxt) begin
            kind = !ph_nxt[2] ? FkNt : (ph_nxt[1] ? FkPtHi : FkPtLo);
        end else if (dum_nxt) begin
            kind = FkNt;
        end
    end

    assign cx_f    = bg_nxt ? coarse_x_d : 5'd0;
    assign cy_f    = (bg_nxt || dum_nxt) ? cy : 5'd0;
    assign pt_tbl  = spr_nxt ? spr_tbl_i : bg_tbl_i;
    assign pt_tile = spr_nxt ? 8'hFF : tile_q;
    assign pt_fy   = spr_nxt ? 3'd0 : row[2:0];
    assign nt_sel  = NtAddrBase | {2'b00, nt_base_i, 10'h000};

    always_comb begin
        addr_d = addr_q;
        oe_d   = oe_q;
        tile_d = tile_q;
        if (dot_ce_i) begin
            if (!oe_q && bg_cur && (ph_cur == 3'd1)) begin
                tile_d = ppu_dat_i;
            end
            if (!fetch_en) begin
                addr_d = 14'd0;
                oe_d   = 1'b1;
            end else if (dot_nxt == 9'd0) begin
                oe_d = 1'b1;
            end else begin
                oe_d = ~ph_nxt[0];
                unique case (kind)
                    FkNt:    addr_d = nt_sel | {4'b0000, cy_f, cx_f};
                    FkAt:    addr_d = nt_sel | {4'b0000, AtOffset} | {8'h00, cy_f[4:2], cx_f[4:2]};
                    FkPtLo:  addr_d = {1'b0, pt_tbl, pt_tile, 1'b0, pt_fy};
                    FkPtHi:  addr_d = {1'b0, pt_tbl, pt_tile, 1'b1, pt_fy};
                    default: addr_d = addr_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q     <= 14'd0;
            oe_q       <= 1'b1;
            tile_q     <= 8'd0;
            coarse_x_q <= 5'd0;
        end else begin
            addr_q     <= addr_d;
            oe_q       <= oe_d;
            tile_q     <= tile_d;
            coarse_x_q <= coarse_x_d;
        end
    end

    assign ppu_addr_o = addr_q;
    assign ppu_oe_o   = oe_q;
    assign dot_o      = dot_cur;

endmodule

// File: tb/tb_ppu_fetch_gen.sv
// Scoreboard bench for ppu_fetch_gen: a per-dot reference model predicts every output,
// a monitor compares after each clock; directed checks cover the key fetch sequences.
module tb_ppu_fetch_gen;

    localparam int D   = 341;
    localparam int L   = 24;
    localparam int VB  = 20;
    localparam int VIS = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dot_ce = 1'b0;
    logic        rend_on = 1'b0;
    logic [1:0]  nt_base = 2'd0;
    logic        bg_tbl = 1'b0;
    logic        spr_tbl = 1'b0;
    logic        mem_5a = 1'b0;
    logic [7:0]  ppu_dat;
    logic [13:0] ppu_addr;
    logic        ppu_oe;
    logic [8:0]  dot, line;
    logic        frame_odd, vblank, nmi_pulse;

    int errors = 0;
    int checks = 0;
    int nmi_cnt = 0;

    logic [35:0] exp_q[$];
    logic [35:0] mon_e, mon_a;

    int m_dot, m_line, m_addr, m_tile;
    bit m_odd, m_vbl, m_nmi, m_oe;

    ppu_fetch_gen #(
        .DOTS      (D),
        .LINES     (L),
        .VBL_LINE  (VB),
        .VIS_LINES (VIS)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .dot_ce_i    (dot_ce),
        .rend_on_i   (rend_on),
        .nt_base_i   (nt_base),
        .bg_tbl_i    (bg_tbl),
        .spr_tbl_i   (spr_tbl),
        .ppu_dat_i   (ppu_dat),
        .ppu_addr_o  (ppu_addr),
        .ppu_oe_o    (ppu_oe),
        .dot_o       (dot),
        .line_o      (line),
        .frame_odd_o (frame_odd),
        .vblank_o    (vblank),
        .nmi_pulse_o (nmi_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] hash(logic [13:0] a);
        return a[7:0] ^ {a[13:10], a[11:8]} ^ 8'h3C;
    endfunction

    always_comb ppu_dat = mem_5a ? 8'h5A : hash(ppu_addr);

    function automatic bit in_bg(int d);
        return (d >= 1 && d <= 256) || (d >= 321 && d <= 336);
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_dot = 0; m_line = 0; m_odd = 0; m_vbl = 0; m_nmi = 0;
        m_addr = 0; m_oe = 1; m_tile = 0;
    endtask

    // One dot of the reference PPU, written from the fetch rules with plain arithmetic.
    task automatic model_step();
        int ph, row, cx, cy, ntb;
        if (!dot_ce) begin
            m_nmi = 0;
            return;
        end
        if (in_bg(m_dot) && ((m_dot - 1) % 8 == 1) && !m_oe)
            m_tile = mem_5a ? 'h5A : int'(hash(14'(m_addr)));
        if (m_dot == D - 1 || (rend_on && m_odd && m_line == L - 1 && m_dot == D - 2)) begin
            m_dot = 0;
            if (m_line == L - 1) begin
                m_line = 0;
                m_odd = !m_odd;
            end else begin
                m_line++;
            end
        end else begin
            m_dot++;
        end
        m_nmi = (m_line == VB && m_dot == 1);
        if (m_nmi) m_vbl = 1;
        if (m_line == L - 1 && m_dot == 1) m_vbl = 0;
        if (!rend_on || !(m_line < VIS || m_line == L - 1)) begin
            m_addr = 0;
            m_oe = 1;
        end else if (m_dot == 0) begin
            m_oe = 1;
        end else begin
            ph = (m_dot - 1) % 8;
            m_oe = (ph % 2 == 0);
            ntb = 'h2000 + int'(nt_base) * 'h400;
            if (m_line == L - 1) row = 0;
            else row = (m_dot <= 256) ? m_line : m_line + 1;
            cy = (row / 8) % 32;
            if (in_bg(m_dot)) begin
                cx = (m_dot <= 256) ? (m_dot - 1) / 8 : (m_dot - 321) / 8;
                case (ph / 2)
                    0: m_addr = ntb + cy * 32 + cx;
                    1: m_addr = ntb + 'h3C0 + (cy / 4) * 8 + cx / 4;
                    2: m_addr = int'(bg_tbl) * 'h1000 + m_tile * 16 + row % 8;
                    default: m_addr = int'(bg_tbl) * 'h1000 + m_tile * 16 + 8 + row % 8;
                endcase
            end else if (m_dot <= 320) begin
                if (ph < 4) m_addr = ntb;
                else m_addr = int'(spr_tbl) * 'h1000 + 'hFF0 + ((ph >= 6) ? 8 : 0);
            end else begin
                m_addr = ntb + cy * 32;
            end
        end
    endtask

    task automatic step(bit ce);
        @(negedge clk);
        dot_ce = ce;
        model_step();
        exp_q.push_back({14'(m_addr), m_oe, 9'(m_dot), 9'(m_line), m_odd, m_vbl, m_nmi});
        @(posedge clk);
        #2;
    endtask

    task automatic run_to(int ln, int dt, int maxn);
        int n = 0;
        while (!(line == 9'(ln) && dot == 9'(dt))) begin
            if (n >= maxn) begin
                checks++;
                errors++;
                $display("FAIL run_to: line %0d dot %0d not reached, at line %0d dot %0d",
                         ln, dt, line, dot);
                return;
            end
            step(1);
            n++;
        end
    endtask

    task automatic measure_pre(string name);
        int n;
        bit odd;
        run_to(L - 1, 0, D * L + 10);
        odd = m_odd;
        n = 1;
        for (int i = 0; i < 400; i++) begin
            step(1);
            if (line != 9'(L - 1)) break;
            n++;
        end
        check(name, n, (rend_on && odd) ? 340 : 341);
    endtask

    always @(posedge clk) begin
        #1;
        if (nmi_pulse) nmi_cnt++;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = {ppu_addr, ppu_oe, dot, line, frame_odd, vblank, nmi_pulse};
            checks++;
            if (mon_a !== mon_e) begin
                errors++;
                $display({"FAIL scoreboard: got addr=%h oe=%b dot=%0d line=%0d odd=%b vbl=%b ",
                          "nmi=%b, expected addr=%h oe=%b dot=%0d line=%0d odd=%b vbl=%b nmi=%b"},
                         mon_a[35:22], mon_a[21], mon_a[20:12], mon_a[11:3], mon_a[2], mon_a[1],
                         mon_a[0], mon_e[35:22], mon_e[21], mon_e[20:12], mon_e[11:3], mon_e[2],
                         mon_e[1], mon_e[0]);
            end
        end
    end

    initial begin
        logic [13:0] bg_exp [8];
        logic [13:0] spr_exp [8];
        logic        oe_exp [8];
        bg_exp  = '{14'h2020, 14'h2020, 14'h23C0, 14'h23C0,
                    14'h15A2, 14'h15A2, 14'h15AA, 14'h15AA};
        spr_exp = '{14'h2000, 14'h2000, 14'h2000, 14'h2000,
                    14'h0FF0, 14'h0FF0, 14'h0FF8, 14'h0FF8};
        oe_exp  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        model_reset();
        repeat (3) @(posedge clk);
        #2;
        check("reset_addr", ppu_addr, 0);
        check("reset_oe", ppu_oe, 1);
        check("reset_dot", dot, 0);
        check("reset_line", line, 0);
        check("reset_odd", frame_odd, 0);
        check("reset_vblank", vblank, 0);
        check("reset_nmi", nmi_pulse, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full frame with rendering off.
        nmi_cnt = 0;
        repeat (D * L) step(1);
        check("nmi_per_frame", nmi_cnt, 1);

        // Pre-render length: rendered odd, rendered even, then unrendered.
        rend_on = 1'b1;
        measure_pre("prerender_rend_a");
        measure_pre("prerender_rend_b");
        rend_on = 1'b0;
        measure_pre("prerender_off");

        // Directed background and sprite sequences on line 10.
        rend_on = 1'b1; nt_base = 2'd0; bg_tbl = 1'b1; spr_tbl = 1'b0; mem_5a = 1'b1;
        run_to(10, 0, D * L + 10);
        for (int i = 0; i < 8; i++) begin
            step(1);
            check($sformatf("bg_addr_dot%0d", i + 1), ppu_addr, bg_exp[i]);
            check($sformatf("bg_oe_dot%0d", i + 1), ppu_oe, oe_exp[i]);
        end
        run_to(10, 256, D);
        for (int i = 0; i < 8; i++) begin
            step(1);
            check($sformatf("spr_addr_dot%0d", 257 + i), ppu_addr, spr_exp[i]);
        end

        // Asynchronous reset in the middle of a pattern fetch.
        run_to(12, 150, 2 * D);
        check("pre_rst_oe", ppu_oe, 0);
        #1;
        rst_n = 1'b0;
        dot_ce = 1'b0;
        #1;
        check("rst_async_oe", ppu_oe, 1);
        check("rst_async_dot", dot, 0);
        check("rst_async_line", line, 0);
        check("rst_async_addr", ppu_addr, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        check("rst_hold_dot", dot, 0);
        step(1);
        check("restart_dot", dot, 1);
        check("restart_addr", ppu_addr, 'h2000);

        // Randomized run: rendering toggles, table/nametable changes, dot_ce gaps.
        mem_5a = 1'b0;
        for (int i = 0; i < 2 * D * L; i++) begin
            if ($urandom_range(0, 499) == 0) rend_on = ~rend_on;
            if ($urandom_range(0, 299) == 0) nt_base = 2'($urandom);
            if ($urandom_range(0, 299) == 0) bg_tbl = 1'($urandom);
            if ($urandom_range(0, 299) == 0) spr_tbl = 1'($urandom);
            step($urandom_range(0, 3) != 0);
        end
        repeat (3) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
